rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (wen/waddr/wdata) between NR_REQ writeback requesters, e.g. EXU result and LSU load data.
- Each requester uses a valid/ready handshake.
- Arbitration is round-robin, so no requester starves.
- The accepted write is registered and presented to the register file one cycle later.
- Writes to register 0 are suppressed, and accepted/dropped writes are counted for performance monitoring.

Parameters:
- NR_REQ, 2, number of writeback requesters (2..8).
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data width.
- CNT_WIDTH, 16, width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NR_REQ  per-requester write request; bit i = requester i.
- req_ready  output  NR_REQ  per-requester accept, combinational.
- req_addr  input  NR_REQ*ADDR_WIDTH  requester i address at [ADDR_WIDTH*(i+1)-1 : ADDR_WIDTH*i].
- req_data  input  NR_REQ*DATA_WIDTH  requester i data, packed the same way.
- hold  input  1  freeze arbitration (debug/flush); no new accepts while high.
- rf_wen  output  1  register-file write enable.
- rf_waddr  output  ADDR_WIDTH  register-file write address.
- rf_wdata  output  DATA_WIDTH  register-file write data.
- grant_id  output  $clog2(NR_REQ)  index of the requester whose write is currently on rf_*.
- wr_count  output  CNT_WIDTH  number of writes issued to the register file.
- drop_count  output  CNT_WIDTH  number of accepted writes to address 0.

Behaviour:

Reset (asynchronous, immediate):
- rf_wen=0, rf_waddr=0, rf_wdata=0, grant_id=0.
- Priority pointer ptr=0; wr_count=0, drop_count=0.
- req_ready is 0 while rst is high.
- A write latched before reset is discarded and never reaches the register file.

Arbitration (combinational, every cycle):
- Scan requesters in the order ptr, ptr+1, …, ptr+NR_REQ-1 (mod NR_REQ).
- The first one with req_valid=1 is the winner w.
- req_ready[w]=1 iff hold=0 and rst=0; every other req_ready bit is 0.
- At most one req_ready bit is ever high.
- A transfer occurs when req_valid[w] and req_ready[w] are both 1.

Requester rules (assertion targets):
- Once req_valid is asserted, it stays high with stable addr/data until the transfer.
- Requesters must not wait for ready before asserting valid.

Pointer update:
- On a transfer, ptr <= (w+1) mod NR_REQ.
- With no transfer, ptr is unchanged. The current winner therefore keeps priority until served.
- Worst-case wait for a valid requester is NR_REQ-1 transfers.

Output stage (latency 1):
- On a transfer, at the next edge:
  - rf_waddr <= req_addr[w], rf_wdata <= req_data[w], grant_id <= w.
  - rf_wen <= (req_addr[w] != 0).
- With no transfer: rf_wen <= 0; rf_waddr, rf_wdata and grant_id hold their values.
- rf_wen is a single-cycle pulse per write. Back-to-back transfers give rf_wen high on consecutive cycles.
- Throughput: one write per cycle.

Address-0 suppression:
- A request with addr=0 is still accepted (req_ready is asserted normally) and ptr advances.
- No rf_wen pulse is produced.
- drop_count increments in the cycle rf_wen would have risen.

Counters:
- wr_count increments on each rf_wen=1 cycle.
- drop_count increments on each accepted address-0 write.
- Both wrap modulo 2^CNT_WIDTH without saturation or flags.

hold:
- While hold=1, req_ready=0 and ptr is frozen.
- An output-stage write already latched still appears on the next cycle.
- After hold deasserts, arbitration resumes from the frozen ptr.

Simultaneous events:
- All requesters valid in one cycle: only the winner transfers.
- Losers keep valid and are served on later cycles in round-robin order.

Boundary cases:
- NR_REQ=2 with ptr=1 and both valid: requester 1 wins.
- The pointer wraps from NR_REQ-1 to 0.

Test Plan:
1. Reset, then requester 0 valid with addr=5, data=0xDEADBEEF for one transfer -> req_ready[0]=1 in the same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, grant_id=0; wr_count=1.
2. Both requesters continuously valid (r0: addr 1, data 0x11; r1: addr 2, data 0x22) for 4 cycles after reset -> grants alternate 0,1,0,1; rf_wen high 4 consecutive cycles; rf_waddr sequence 1,2,1,2.
3. Requester 1 writes addr=0, data=0x55 -> req_ready[1]=1; no rf_wen pulse; drop_count=1, wr_count unchanged; ptr advances to 0.
4. hold=1 for 3 cycles with both requesters valid -> req_ready=00 throughout, rf_wen=0 from the second cycle; after release the winner is the requester indicated by the frozen ptr.
5. Assert rst asynchronously between edges, one cycle after a transfer to addr=7 -> rf_wen, rf_waddr, counters and ptr go to 0 immediately; no write to addr 7 ever appears.
6. Set CNT_WIDTH=4 and perform 17 writes to nonzero addresses -> wr_count reads 1 after the 17th write.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NR_REQ writeback requesters.
// Accepted write lands on rf_* one cycle later; only the winner sees ready, hold/rst stall all.
module rf_wb_arbiter #(
  parameter int NR_REQ     = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  localparam int GW        = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_REQ-1:0]            req_valid,
  output logic [NR_REQ-1:0]            req_ready,
  input  logic [NR_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NR_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                         hold,
  output logic                         rf_wen,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata,
  output logic [GW-1:0]                grant_id,
  output logic [CNT_WIDTH-1:0]         wr_count,
  output logic [CNT_WIDTH-1:0]         drop_count
);

  logic [GW-1:0]         ptr_q, ptr_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;

  logic                  found;
  int                    win_idx;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    for (int k = 0; k < NR_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NR_REQ) idx = idx - NR_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_comb begin
    xfer      = found && !hold && !rst;
    req_ready = '0;
    if (xfer) req_ready[win_idx] = 1'b1;
    win_addr  = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    win_data  = req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    ptr_d        = ptr_q;
    rf_wen_d     = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    grant_id_d   = grant_id_q;
    wr_count_d   = wr_count_q;
    drop_count_d = drop_count_q;
    if (xfer) begin
      ptr_d      = (win_idx == NR_REQ - 1) ? '0 : GW'(win_idx + 1);
      rf_waddr_d = win_addr;
      rf_wdata_d = win_data;
      grant_id_d = GW'(win_idx);
      // Address-0 writes are consumed but never reach the register file.
      if (win_addr != '0) begin
        rf_wen_d   = 1'b1;
        wr_count_d = wr_count_q + 1'b1;
      end else begin
        drop_count_d = drop_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      grant_id_q   <= '0;
      wr_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      grant_id_q   <= grant_id_d;
      wr_count_q   <= wr_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign rf_wen     = rf_wen_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign grant_id   = grant_id_q;
  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

  // A pending request must hold valid and its payload until accepted.
  for (genvar i = 0; i < NR_REQ; i++) begin : g_req_chk
    a_req_stable: assert property (@(posedge clk) disable iff (rst)
      ($past(!rst) && $past(req_valid[i] && !req_ready[i])) |->
        (req_valid[i] &&
         $stable(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
         $stable(req_data[i*DATA_WIDTH +: DATA_WIDTH])));
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed vector bench for rf_wb_arbiter (default config plus a 4-bit-counter instance).
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready, r4_ready;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_data = '0;
  logic        hold = 1'b0;
  logic        rf_wen, r4_wen;
  logic [4:0]  rf_waddr, r4_waddr;
  logic [31:0] rf_wdata, r4_wdata;
  logic        grant_id, r4_gid;
  logic [15:0] wr_count, drop_count;
  logic [3:0]  r4_wr, r4_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .hold(hold),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .grant_id(grant_id), .wr_count(wr_count), .drop_count(drop_count)
  );

  rf_wb_arbiter #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r4_ready),
    .req_addr(req_addr), .req_data(req_data), .hold(hold),
    .rf_wen(r4_wen), .rf_waddr(r4_waddr), .rf_wdata(r4_wdata),
    .grant_id(r4_gid), .wr_count(r4_wr), .drop_count(r4_drop)
  );

  typedef struct {
    logic        do_rst;
    logic [1:0]  v;
    logic        hold;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [1:0]  rdy;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        gid;
    logic [15:0] wr;
    logic [15:0] drop;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic h, input logic [4:0] a0,
                       input logic [31:0] d0, input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v;
    hold      = h;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_wen",   {63'd0, rf_wen}, 64'd0);
    chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_wdata", {32'd0, rf_wdata}, 64'd0);
    chk("rst_gid",   {63'd0, grant_id}, 64'd0);
    chk("rst_wr",    {48'd0, wr_count}, 64'd0);
    chk("rst_drop",  {48'd0, drop_count}, 64'd0);
  endtask

  initial begin
    // do_rst v hold a0 d0 a1 d1 | rdy wen waddr wdata gid wr drop
    tbl[0]  = '{1'b0, 2'b01, 1'b0, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  2'b01, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 16'd1, 16'd0};
    tbl[1]  = '{1'b0, 2'b00, 1'b0, 5'd0, 32'h0,        5'd0, 32'h0,  2'b00, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 16'd1, 16'd0};
    tbl[2]  = '{1'b1, 2'b11, 1'b0, 5'd1, 32'h11,       5'd2, 32'h22, 2'b01, 1'b1, 5'd1, 32'h11, 1'b0, 16'd1, 16'd0};
    tbl[3]  = '{1'b0, 2'b11, 1'b0, 5'd1, 32'h11,       5'd2, 32'h22, 2'b10, 1'b1, 5'd2, 32'h22, 1'b1, 16'd2, 16'd0};
    tbl[4]  = '{1'b0, 2'b11, 1'b0, 5'd1, 32'h11,       5'd2, 32'h22, 2'b01, 1'b1, 5'd1, 32'h11, 1'b0, 16'd3, 16'd0};
    tbl[5]  = '{1'b0, 2'b11, 1'b0, 5'd1, 32'h11,       5'd2, 32'h22, 2'b10, 1'b1, 5'd2, 32'h22, 1'b1, 16'd4, 16'd0};
    tbl[6]  = '{1'b0, 2'b11, 1'b0, 5'd1, 32'h11,       5'd0, 32'h55, 2'b01, 1'b1, 5'd1, 32'h11, 1'b0, 16'd5, 16'd0};
    tbl[7]  = '{1'b0, 2'b10, 1'b0, 5'd1, 32'h11,       5'd0, 32'h55, 2'b10, 1'b0, 5'd0, 32'h55, 1'b1, 16'd5, 16'd1};
    tbl[8]  = '{1'b0, 2'b01, 1'b0, 5'd6, 32'h66,       5'd0, 32'h55, 2'b01, 1'b1, 5'd6, 32'h66, 1'b0, 16'd6, 16'd1};
    tbl[9]  = '{1'b0, 2'b11, 1'b1, 5'd3, 32'h33,       5'd4, 32'h44, 2'b00, 1'b0, 5'd6, 32'h66, 1'b0, 16'd6, 16'd1};
    tbl[10] = '{1'b0, 2'b11, 1'b1, 5'd3, 32'h33,       5'd4, 32'h44, 2'b00, 1'b0, 5'd6, 32'h66, 1'b0, 16'd6, 16'd1};
    tbl[11] = '{1'b0, 2'b11, 1'b1, 5'd3, 32'h33,       5'd4, 32'h44, 2'b00, 1'b0, 5'd6, 32'h66, 1'b0, 16'd6, 16'd1};
    tbl[12] = '{1'b0, 2'b11, 1'b0, 5'd3, 32'h33,       5'd4, 32'h44, 2'b10, 1'b1, 5'd4, 32'h44, 1'b1, 16'd7, 16'd1};
    tbl[13] = '{1'b0, 2'b01, 1'b0, 5'd3, 32'h33,       5'd4, 32'h44, 2'b01, 1'b1, 5'd3, 32'h33, 1'b0, 16'd8, 16'd1};

    do_reset();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].do_rst) do_reset();
      drive(tbl[i].v, tbl[i].hold, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("v%0d_rdy", i), {62'd0, req_ready}, {62'd0, tbl[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wen", i),   {63'd0, rf_wen},     {63'd0, tbl[i].wen});
      chk($sformatf("v%0d_waddr", i), {59'd0, rf_waddr},   {59'd0, tbl[i].waddr});
      chk($sformatf("v%0d_wdata", i), {32'd0, rf_wdata},   {32'd0, tbl[i].wdata});
      chk($sformatf("v%0d_gid", i),   {63'd0, grant_id},   {63'd0, tbl[i].gid});
      chk($sformatf("v%0d_wr", i),    {48'd0, wr_count},   {48'd0, tbl[i].wr});
      chk($sformatf("v%0d_drop", i),  {48'd0, drop_count}, {48'd0, tbl[i].drop});
    end

    // Async reset while a write to addr 7 is sitting on the output stage.
    drive(2'b01, 1'b0, 5'd7, 32'h77, 5'd0, 32'h0);
    #1 chk("r5_rdy", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("r5_wen_pre",   {63'd0, rf_wen},   64'd1);
    chk("r5_waddr_pre", {59'd0, rf_waddr}, 64'd7);
    drive(2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("r5_wen_async",   {63'd0, rf_wen},     64'd0);
    chk("r5_waddr_async", {59'd0, rf_waddr},   64'd0);
    chk("r5_wr_async",    {48'd0, wr_count},   64'd0);
    chk("r5_drop_async",  {48'd0, drop_count}, 64'd0);
    drive(2'b11, 1'b0, 5'd1, 32'h11, 5'd2, 32'h22);
    #1 chk("r5_rdy_in_rst", {62'd0, req_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("r5_wen_post", {63'd0, rf_wen}, 64'd0);
    #1 chk("r5_rdy_ptr0", {62'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("r5_waddr_a", {59'd0, rf_waddr}, 64'd1);
    chk("r5_gid_a",   {63'd0, grant_id}, 64'd0);
    drive(2'b10, 1'b0, 5'd1, 32'h11, 5'd2, 32'h22);
    #1 chk("r5_rdy_b", {62'd0, req_ready}, 64'd2);
    @(posedge clk);
    #1;
    chk("r5_waddr_b", {59'd0, rf_waddr}, 64'd2);
    chk("r5_gid_b",   {63'd0, grant_id}, 64'd1);
    drive(2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);

    // 17 back-to-back writes: the 4-bit counter wraps to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(2'b01, 1'b0, 5'd9, i, 5'd0, 32'h0);
      @(posedge clk);
      #1 chk($sformatf("w%0d_wen", i), {63'd0, rf_wen}, 64'd1);
    end
    drive(2'b00, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("wrap_wr4",    {60'd0, r4_wr},     64'd1);
    chk("wrap_wr16",   {48'd0, wr_count},  64'd17);
    chk("wrap_wdata4", {32'd0, r4_wdata},  64'd16);
    @(posedge clk);
    #1 chk("wrap_wen_off", {63'd0, rf_wen}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
